multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Moore FSM that sequences the shared multicycle datapath (one memory, one ALU, PC/IR/A/B/ALUOut regs).
//  Decodes the opcode latched in IR and issues per-state datapath strobes; o_alu_op feeds the funct-level ALU decoder.
//  Stalls on memory handshake; traps or skips illegal opcodes.
// PARAMETERS
//  TRAP_ON_ILLEGAL  1  1: illegal opcode -> TRAP (halt until reset); 0: treat as NOP, return to FETCH
// PORTS
//  i_clk            in   1  clock, rising edge
//  i_rst_n          in   1  asynchronous active-low reset
//  i_run            in   1  1: leave IDLE and execute; sampled only in IDLE
//  i_opcode         in   6  IR[31:26], valid from DECODE onward
//  i_zero           in   1  ALU zero flag (BRANCH state)
//  i_mem_ready      in   1  memory completes access this cycle
//  o_pc_write       out  1  unconditional PC load
//  o_branch         out  1  PC load qualified by i_zero (datapath ANDs)
//  o_iord           out  1  0: mem addr = PC, 1: mem addr = ALUOut
//  o_mem_rd         out  1  memory read request
//  o_mem_wr         out  1  memory write request
//  o_ir_write       out  1  load IR
//  o_reg_dst        out  1  0: rt, 1: rd
//  o_mem_to_reg     out  1  0: ALUOut, 1: MDR
//  o_reg_wr         out  1  register-file write enable
//  o_alu_src_a      out  1  0: PC, 1: A
//  o_alu_src_b      out  2  00: B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
//  o_alu_op         out  2  00 add, 01 sub, 10 funct-decoded
//  o_pc_src         out  2  00: ALU result, 01: ALUOut, 10: jump target
//  o_retire         out  1  one-cycle pulse when an instruction completes
//  o_illegal        out  1  one-cycle pulse on illegal opcode in DECODE
//  o_state          out  4  current state encoding (debug)
// BEHAVIOUR
//  Reset: state = IDLE; all outputs 0 (outputs are a pure function of the state register; IDLE drives all 0).
//  States/outputs (unlisted outputs = 0):
//   IDLE    : -> FETCH if i_run, else stay.
//   FETCH   : mem_rd, alu_src_b=01, alu_op=00; while !i_mem_ready stay, no PC/IR write;
//             ir_write and pc_write asserted only when i_mem_ready=1 (combinational qualifier) -> DECODE.
//   DECODE  : alu_src_b=11, alu_op=00 (branch target -> ALUOut). Next by opcode:
//             000000 R -> EXEC; 100011 lw/101011 sw -> MEMADR; 000100 beq -> BRANCH;
//             001000 addi -> ADDIEX; 000010 j -> JUMP; other -> o_illegal, TRAP or FETCH per TRAP_ON_ILLEGAL.
//   MEMADR  : alu_src_a=1, alu_src_b=10, alu_op=00 -> MEMRD (lw) / MEMWR (sw).
//   MEMRD   : iord=1, mem_rd=1; stay until i_mem_ready -> MEMWB.
//   MEMWB   : reg_wr=1, mem_to_reg=1, reg_dst=0, retire -> FETCH.
//   MEMWR   : iord=1, mem_wr=1; stay until i_mem_ready; retire on ready -> FETCH.
//   EXEC    : alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
//   ALUWB   : reg_wr=1, reg_dst=1, mem_to_reg=0, retire -> FETCH.
//   BRANCH  : alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01, retire -> FETCH.
//   ADDIEX  : alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
//   ADDIWB  : reg_wr=1, reg_dst=0, retire -> FETCH.
//   JUMP    : pc_write=1, pc_src=10, retire -> FETCH.
//   TRAP    : all 0; exits only via reset.
//  Latency (cycles incl. FETCH, zero wait): lw 5, sw 4, R 4, addi 4, beq 3, j 3; each wait cycle adds 1.
//  i_run ignored outside IDLE; machine never returns to IDLE except by reset.
//  Reset asserted mid-instruction: immediate return to IDLE, all strobes drop same instant (async);
//   a partially issued mem_wr/reg_wr is abandoned, no retire.
//  mem_rd and mem_wr never both 1; reg_wr and pc_write never both 1 in any state.
//  Unused state encodings -> IDLE next cycle (default arm).
// STRUCTURE
//  Shared package/header: opcode constants, state encodings (4-bit), ALUOp, ALUSrcB, PCSrc codes.
//  Single module; next-state and output decode as two combinational blocks + one state register.
//  No sub-module needed; funct decode stays in the existing ALU decoder downstream.
// TESTING
//  Reset low mid-MEMWR (mem_wr=1) -> all outputs 0 immediately, o_state=IDLE, no o_retire.
//  i_run=1, opcode 100011, i_mem_ready=1 always -> IDLE,FETCH,DECODE,MEMADR,MEMRD,MEMWB; retire in MEMWB.
//  FETCH with i_mem_ready low 3 cycles -> ir_write/pc_write stay 0 those cycles, pulse once on ready.
//  opcode 000100, i_zero=1 -> BRANCH: branch=1, pc_src=01, alu_op=01; 3 cycles FETCH->FETCH.
//  opcode 000000 then 000010 back-to-back -> R in 4 cycles (alu_op=10 in EXEC, reg_dst=1), j in 3 (pc_src=10).
//  opcode 111111, TRAP_ON_ILLEGAL=1 -> o_illegal pulse, TRAP held 20 cycles; =0 -> FETCH next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants for the multicycle controller: opcodes, state encodings,
// datapath select codes and the bundle of control strobes.
package multicycle_ctrl_fsm_pkg;

  // IR[31:26] opcodes understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // 4-bit state encodings; 14 and 15 are unused and recover to IDLE
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  // ALU operation class handed to the funct-level decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All datapath strobes issued in one cycle
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_legal = 1'b1;
      default:                                       opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Moore-style controller sequencing a shared multicycle datapath (one memory,
// one ALU, PC/IR/A/B/ALUOut registers).
// Ports:
//   i_clk, i_rst_n      clock (rising) / asynchronous active-low reset
//   i_run               start execution; only looked at in IDLE
//   i_opcode            IR[31:26], valid from DECODE onward
//   i_zero              ALU zero flag; the datapath ANDs it with o_branch
//   i_mem_ready         memory finishes the current access this cycle
//   o_*                 datapath strobes / selects, o_retire and o_illegal
//                       one-cycle pulses, o_state current state (debug)
// Outputs come from the state register; the only input qualifiers are
// i_mem_ready (FETCH IR/PC load, MEMWR retire) and i_opcode (DECODE illegal).
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_branch,
  output logic       o_iord,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_wr,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic       o_retire,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  // Branch qualification by the zero flag is done in the datapath, so the
  // flag is carried on the interface but not consumed here.
  logic unused_zero;
  assign unused_zero = i_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_run) state_d = S_FETCH;
      S_FETCH:  if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (i_mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;   // only reset leaves TRAP
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        // IR and PC+4 commit only on the cycle the read completes
        ctrl.ir_write  = i_mem_ready;
        ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // speculative branch target into ALUOut
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = ~opcode_legal(i_opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_rd = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_wr = 1'b1;
        ctrl.retire = i_mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = 1'b1;
        ctrl.retire  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.retire    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_wr = 1'b1;
        ctrl.retire = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.retire   = 1'b1;
      end
      default: ctrl = '0;   // IDLE, TRAP, unused encodings
    endcase
  end

  assign o_pc_write   = ctrl.pc_write;
  assign o_branch     = ctrl.branch;
  assign o_iord       = ctrl.iord;
  assign o_mem_rd     = ctrl.mem_rd;
  assign o_mem_wr     = ctrl.mem_wr;
  assign o_ir_write   = ctrl.ir_write;
  assign o_reg_dst    = ctrl.reg_dst;
  assign o_mem_to_reg = ctrl.mem_to_reg;
  assign o_reg_wr     = ctrl.reg_wr;
  assign o_alu_src_a  = ctrl.alu_src_a;
  assign o_alu_src_b  = ctrl.alu_src_b;
  assign o_alu_op     = ctrl.alu_op;
  assign o_pc_src     = ctrl.pc_src;
  assign o_retire     = ctrl.retire;
  assign o_illegal    = ctrl.illegal;
  assign o_state      = state_q;

endmodule
